// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled. It synchronizes rx, finds the start bit, samples
// each bit at mid-bit and presents the word with a one-clk completion tick.
module uart_rx #(
    parameter int unsigned D_BIT   = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    input  logic       i_s_tick,
    output logic [7:0] o_dout,
    output logic       o_rx_done_tick,
    output logic       o_frame_err
);

    localparam logic [4:0]  StopLast = 5'(SB_TICK - 1);
    localparam logic [2:0]  BitLast  = 3'(D_BIT - 1);
    localparam int unsigned Pad      = 8 - D_BIT;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e     r_state, w_state_next;
    logic       r_sync1, r_sync2;
    logic       w_rxs;
    logic [4:0] r_s, w_s_next;
    logic [2:0] r_n, w_n_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_armed, w_armed_next;
    logic [7:0] r_dout, w_dout_next;
    logic       r_done, w_done_next;
    logic       r_ferr, w_ferr_next;

    assign w_rxs = r_sync2;

    // State register plus datapath registers and the two-flop rx synchronizer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_armed <= 1'b1;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_shift <= w_shift_next;
            r_armed <= w_armed_next;
            r_dout  <= w_dout_next;
            r_done  <= w_done_next;
            r_ferr  <= w_ferr_next;
        end
    end

    // Next-state logic; everything but the start-edge search waits for s_tick.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_shift_next = r_shift;
        w_armed_next = r_armed;
        w_dout_next  = r_dout;
        w_done_next  = 1'b0;
        w_ferr_next  = r_ferr;
        unique case (r_state)
            StIdle: begin
                if (w_rxs) begin
                    w_armed_next = 1'b1;
                end
                // armed blocks a restart while a break holds the line low
                if (r_armed && !w_rxs) begin
                    w_state_next = StStart;
                    w_s_next     = '0;
                end
            end
            StStart: begin
                if (i_s_tick) begin
                    if (r_s == 5'd7) begin
                        if (!w_rxs) begin
                            w_state_next = StData;
                            w_s_next     = '0;
                            w_n_next     = '0;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            StData: begin
                if (i_s_tick) begin
                    if (r_s == 5'd15) begin
                        w_shift_next = {w_rxs, r_shift[7:1]};
                        w_s_next     = '0;
                        if (r_n == BitLast) begin
                            w_state_next = StStop;
                        end else begin
                            w_n_next = r_n + 3'd1;
                        end
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            StStop: begin
                if (i_s_tick) begin
                    if (r_s == StopLast) begin
                        w_state_next = StIdle;
                        w_armed_next = w_rxs;
                        // fewer than 8 bits sit in the top of the shifter
                        w_dout_next  = r_shift >> Pad;
                        w_ferr_next  = ~w_rxs;
                        w_done_next  = 1'b1;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        o_dout         = r_dout;
        o_rx_done_tick = r_done;
        o_frame_err    = r_ferr;
    end

endmodule
